// File: rtl/mem_bus_interconnect_pkg.sv
// Shared memory-bus types: command, read result, address window, window hit test.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package mem_bus_interconnect_pkg;

   localparam int          BUS_ADDR_W          = 30;
   localparam logic [29:0] PC_VALID_RANGE_BASE = 30'h0010_0000;
   localparam int          RAM_WIDTH           = 12;

   typedef logic [31:0] result_t;

   typedef struct packed {
      logic        mem_read;
      logic [3:0]  mask_byte;
      logic [31:0] write_data;
   } cmd_t;

   typedef struct packed {
      logic [29:0] base;
      logic [29:0] size;
   } window_t;

   // One extra bit on the upper bound so a window ending at 2**30 does not wrap to 0.
   function automatic logic in_window(input logic [29:0] addr, input window_t w);
      logic [30:0] hi;
      hi = {1'b0, w.base} + {1'b0, w.size};
      return ({1'b0, addr} >= {1'b0, w.base}) && ({1'b0, addr} < hi);
   endfunction

endpackage

// File: rtl/mem_bus_interconnect_arb.sv
// Bus arbiter: one-hot grant over req, round-robin (RR_MODE=1) or fixed priority (index 0 highest).
// Latency: combinational grant in the request cycle; last_gnt updates on the following edge.
// Backpressure: masters not granted simply keep req high; no grant at all while rst is high.
module rr_arbiter
#(
   parameter int N       = 2,
   parameter int RR_MODE = 1,
   parameter int IW      = (N > 1) ? $clog2(N) : 1
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   logic [IW-1:0] last_gnt;
   logic [IW-1:0] cand;
   logic          found;

   // Search order starts just after the last winner in RR mode, at index 0 otherwise.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = '0;
      if (!rst) begin
         for (int k = 0; k < N; k++) begin
            if (RR_MODE != 0) cand = IW'((int'(last_gnt) + 1 + k) % N);
            else              cand = IW'(k);
            if (!found && req[cand]) begin
               found       = 1'b1;
               gnt[cand]   = 1'b1;
               gnt_idx     = cand;
            end
         end
      end
   end

   // Reset to the top index so master 0 is first in line.
   always_ff @(posedge clk) begin
      if (rst)        last_gnt <= IW'(N - 1);
      else if (found) last_gnt <= gnt_idx;
   end

endmodule

// File: rtl/mem_bus_interconnect.sv
// N-master / M-slave memory interconnect: arbitrate, decode onto address windows, route read data, log misses.
// Latency: grant and slave strobe in cycle t; rvalid/result/err in t+1; one transaction per cycle.
// Backpressure: losing masters hold m_req until m_gnt; slaves cannot stall. Ports: m_* master side, s_* slave side, err_* miss log.
module mem_bus_interconnect
   import mem_bus_interconnect_pkg::*;
#(
   parameter int      NUM_MASTERS = 2,
   parameter int      NUM_SLAVES  = 2,
   parameter int      ADDR_W      = 30,
   parameter window_t WINDOWS [NUM_SLAVES] = '{
      '{base: PC_VALID_RANGE_BASE, size: 30'(2**RAM_WIDTH)},
      '{base: 30'h100,             size: 30'd4}},
   parameter int      RR_MODE     = 1
)
(
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [NUM_MASTERS-1:0]                   m_req,
   input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]       m_address,
   input  logic [NUM_MASTERS-1:0]                   m_we,
   input  cmd_t [NUM_MASTERS-1:0]                   m_cmd,
   output logic [NUM_MASTERS-1:0]                   m_gnt,
   output logic [NUM_MASTERS-1:0]                   m_rvalid,
   output result_t                                  m_result,
   output logic [NUM_MASTERS-1:0]                   m_err,
   output logic [NUM_SLAVES-1:0][ADDR_W-1:0]        s_address,
   output logic [NUM_SLAVES-1:0]                    s_we,
   output cmd_t [NUM_SLAVES-1:0]                    s_cmd,
   input  result_t [NUM_SLAVES-1:0]                 s_result,
   output logic [15:0]                              err_count,
   output logic [ADDR_W-1:0]                        err_address
);

   localparam int MIW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int SIW = (NUM_SLAVES  > 1) ? $clog2(NUM_SLAVES)  : 1;

   logic [MIW-1:0]    gnt_idx;
   logic              any_gnt;
   logic [ADDR_W-1:0] g_addr;
   logic              g_we;
   cmd_t              g_cmd;
   logic              sel_vld;
   logic [SIW-1:0]    sel_idx;
   logic              strobe;

   // Registered response of the cycle-t transaction.
   logic              rd_pend;
   logic              er_pend;
   logic [MIW-1:0]    rsp_master;
   logic [SIW-1:0]    rsp_slave;

   rr_arbiter #(.N(NUM_MASTERS), .RR_MODE(RR_MODE), .IW(MIW)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (m_req),
      .gnt     (m_gnt),
      .gnt_idx (gnt_idx)
   );

   assign any_gnt = |m_gnt;
   assign g_addr  = m_address[gnt_idx];
   assign g_we    = m_we[gnt_idx];
   assign g_cmd   = m_cmd[gnt_idx];

   // Walk from the top index down so the lowest-indexed overlapping window wins.
   always_comb begin
      sel_vld = 1'b0;
      sel_idx = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if (in_window(BUS_ADDR_W'(g_addr), WINDOWS[i])) begin
            sel_vld = 1'b1;
            sel_idx = SIW'(i);
         end
      end
   end

   // Address and write data fan out to every slave; only the selected one sees a strobe.
   always_comb begin
      strobe = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         strobe                = any_gnt && sel_vld && (sel_idx == SIW'(i));
         s_address[i]          = g_addr - ADDR_W'(WINDOWS[i].base);
         s_we[i]               = g_we && strobe;
         s_cmd[i]              = g_cmd;
         s_cmd[i].mem_read     = g_cmd.mem_read && strobe;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pend     <= 1'b0;
         er_pend     <= 1'b0;
         rsp_master  <= '0;
         rsp_slave   <= '0;
         err_count   <= '0;
         err_address <= '0;
      end else begin
         // A read miss still answers (with zero data) so the master is never left waiting.
         rd_pend    <= any_gnt && g_cmd.mem_read;
         er_pend    <= any_gnt && !sel_vld;
         rsp_master <= gnt_idx;
         rsp_slave  <= sel_idx;
         if (any_gnt && !sel_vld) begin
            err_address <= g_addr;
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
         end
      end
   end

   // Gated by rst so a reset in t+1 drops the outstanding response immediately.
   always_comb begin
      m_rvalid = '0;
      m_err    = '0;
      m_result = '0;
      if (!rst) begin
         if (rd_pend) begin
            m_rvalid[rsp_master] = 1'b1;
            if (!er_pend) m_result = s_result[rsp_slave];
         end
         if (er_pend) m_err[rsp_master] = 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_bus_interconnect.sv
module tb_mem_bus_interconnect;
   import mem_bus_interconnect_pkg::*;

   localparam logic [29:0] RAM_BASE = PC_VALID_RANGE_BASE;
   localparam logic [29:0] MISS_A   = 30'h3FFF_FFFF;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [1:0]            m_req;
   logic [1:0][29:0]      m_address;
   logic [1:0]            m_we;
   cmd_t [1:0]            m_cmd;
   result_t [1:0]         s_result;

   logic [1:0]            m_gnt, m_rvalid, m_err;
   result_t               m_result;
   logic [1:0][29:0]      s_address;
   logic [1:0]            s_we;
   cmd_t [1:0]            s_cmd;
   logic [15:0]           err_count;
   logic [29:0]           err_address;

   logic [1:0]            f_m_gnt, f_m_rvalid, f_m_err;
   result_t               f_m_result;
   logic [1:0][29:0]      f_s_address;
   logic [1:0]            f_s_we;
   cmd_t [1:0]            f_s_cmd;
   logic [15:0]           f_err_count;
   logic [29:0]           f_err_address;

   always #5 clk = ~clk;

   mem_bus_interconnect #(.NUM_MASTERS(2), .NUM_SLAVES(2), .ADDR_W(30), .RR_MODE(1)) dut (
      .clk(clk), .rst(rst), .m_req(m_req), .m_address(m_address), .m_we(m_we), .m_cmd(m_cmd),
      .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_result(m_result), .m_err(m_err),
      .s_address(s_address), .s_we(s_we), .s_cmd(s_cmd), .s_result(s_result),
      .err_count(err_count), .err_address(err_address));

   mem_bus_interconnect #(.NUM_MASTERS(2), .NUM_SLAVES(2), .ADDR_W(30), .RR_MODE(0)) dut_fixed (
      .clk(clk), .rst(rst), .m_req(m_req), .m_address(m_address), .m_we(m_we), .m_cmd(m_cmd),
      .m_gnt(f_m_gnt), .m_rvalid(f_m_rvalid), .m_result(f_m_result), .m_err(f_m_err),
      .s_address(f_s_address), .s_we(f_s_we), .s_cmd(f_s_cmd), .s_result(s_result),
      .err_count(f_err_count), .err_address(f_err_address));

   typedef struct {
      logic [1:0]  rvalid;
      logic [1:0]  err;
      logic [31:0] result;
      bit          chk_log;
      logic [15:0] cnt;
      logic [29:0] addr;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [1:0] rv, input logic [1:0] er, input logic [31:0] res,
                       input bit cl, input logic [15:0] cnt, input logic [29:0] addr);
      exp_t e;
      e.rvalid = rv; e.err = er; e.result = res; e.chk_log = cl; e.cnt = cnt; e.addr = addr;
      q.push_back(e);
   endtask

   task automatic drive(input logic [1:0] req, input logic [29:0] a0, input logic [29:0] a1,
                        input logic [1:0] we, input logic [1:0] rd);
      @(posedge clk);
      #1;
      m_req        = req;
      m_address[0] = a0;
      m_address[1] = a1;
      m_we         = we;
      for (int i = 0; i < 2; i++) begin
         m_cmd[i].mem_read   = rd[i];
         m_cmd[i].mask_byte  = 4'hF;
         m_cmd[i].write_data = 32'h41;
      end
      @(negedge clk);
   endtask

   // Response monitor: every presented response must match the oldest expectation.
   always @(negedge clk) begin
      if (mon_en) begin
         if (m_rvalid != 2'b00 || m_err != 2'b00) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: got rvalid=%b err=%b expected no response", m_rvalid, m_err);
            end else begin
               mon_e = q.pop_front();
               check("rsp_rvalid", 64'(m_rvalid), 64'(mon_e.rvalid));
               check("rsp_err",    64'(m_err),    64'(mon_e.err));
               check("rsp_result", 64'(m_result), 64'(mon_e.result));
               if (mon_e.chk_log) begin
                  check("err_count",   64'(err_count),   64'(mon_e.cnt));
                  check("err_address", 64'(err_address), 64'(mon_e.addr));
               end
            end
         end else begin
            check("idle_result", 64'(m_result), 64'd0);
         end
      end
   end

   logic [1:0] rr_exp [4];
   logic [1:0] fx_exp [4];

   initial begin
      rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
      fx_exp[0] = 2'b01; fx_exp[1] = 2'b01; fx_exp[2] = 2'b01; fx_exp[3] = 2'b01;
      s_result[0] = 32'hDEAD_BEEF;
      s_result[1] = 32'h0000_1234;
      rst = 1'b1;
      m_req = 2'b00; m_address = '0; m_we = 2'b00; m_cmd = '0;

      // Requests during reset must not be granted or strobed.
      drive(2'b11, RAM_BASE, RAM_BASE, 2'b00, 2'b11);
      check("rst_gnt",    64'(m_gnt), 64'd0);
      check("rst_s_rd0",  64'(s_cmd[0].mem_read), 64'd0);
      drive(2'b00, 30'd0, 30'd0, 2'b00, 2'b00);
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;
      check("reset_rvalid", 64'(m_rvalid), 64'd0);
      check("reset_err",    64'(m_err),    64'd0);
      check("reset_cnt",    64'(err_count), 64'd0);
      check("reset_eaddr",  64'(err_address), 64'd0);

      // Both masters read for 4 cycles: RR alternates from master 0, fixed always master 0.
      for (int i = 0; i < 4; i++) begin
         drive(2'b11, RAM_BASE, RAM_BASE + 30'd8, 2'b00, 2'b11);
         check("rr_gnt",    64'(m_gnt),   64'(rr_exp[i]));
         check("fixed_gnt", 64'(f_m_gnt), 64'(fx_exp[i]));
         push(rr_exp[i], 2'b00, 32'hDEAD_BEEF, 1'b0, 16'd0, 30'd0);
      end
      drive(2'b00, 30'd0, 30'd0, 2'b00, 2'b00);

      // Single master read from RAM base+4.
      drive(2'b01, RAM_BASE + 30'd4, 30'd0, 2'b00, 2'b01);
      check("rd_gnt",   64'(m_gnt), 64'd1);
      check("rd_saddr", 64'(s_address[0]), 64'd4);
      check("rd_s0_rd", 64'(s_cmd[0].mem_read), 64'd1);
      check("rd_s1_rd", 64'(s_cmd[1].mem_read), 64'd0);
      check("rd_we",    64'(s_we), 64'd0);
      push(2'b01, 2'b00, 32'hDEAD_BEEF, 1'b0, 16'd0, 30'd0);

      // Same master again in RR mode: single requester keeps the grant.
      drive(2'b01, RAM_BASE + 30'hFFF, 30'd0, 2'b00, 2'b01);
      check("rr_single_gnt", 64'(m_gnt), 64'd1);
      check("ram_top_saddr", 64'(s_address[0]), 64'hFFF);
      push(2'b01, 2'b00, 32'hDEAD_BEEF, 1'b0, 16'd0, 30'd0);

      // Master 1 writes 'h41 to 'h100: no response expected.
      drive(2'b10, 30'd0, 30'h100, 2'b10, 2'b00);
      check("wr_gnt",   64'(m_gnt), 64'd2);
      check("wr_s_we",  64'(s_we), 64'b10);
      check("wr_saddr", 64'(s_address[1]), 64'd0);
      check("wr_data",  64'(s_cmd[1].write_data), 64'h41);

      // Master 1 reads the last word of the IO window.
      drive(2'b10, 30'd0, 30'h103, 2'b00, 2'b10);
      check("io_saddr", 64'(s_address[1]), 64'd3);
      check("io_s1_rd", 64'(s_cmd[1].mem_read), 64'd1);
      push(2'b10, 2'b00, 32'h0000_1234, 1'b0, 16'd0, 30'd0);

      // Unmapped read.
      drive(2'b01, MISS_A, 30'd0, 2'b00, 2'b01);
      check("miss_gnt",  64'(m_gnt), 64'd1);
      check("miss_rd",   64'({s_cmd[1].mem_read, s_cmd[0].mem_read}), 64'd0);
      check("miss_we",   64'(s_we), 64'd0);
      push(2'b01, 2'b01, 32'd0, 1'b1, 16'd1, MISS_A);

      // One past the IO window and one past RAM are misses too.
      drive(2'b10, 30'd0, 30'h104, 2'b00, 2'b10);
      check("io_end_rd", 64'(s_cmd[1].mem_read), 64'd0);
      push(2'b10, 2'b10, 32'd0, 1'b1, 16'd2, 30'h104);
      drive(2'b01, RAM_BASE + 30'h1000, 30'd0, 2'b01, 2'b00);
      check("ram_end_we", 64'(s_we), 64'd0);
      push(2'b00, 2'b01, 32'd0, 1'b1, 16'd3, RAM_BASE + 30'h1000);
      drive(2'b00, 30'd0, 30'd0, 2'b00, 2'b00);

      // Read granted, then reset in the response cycle: response dropped.
      drive(2'b01, RAM_BASE, 30'd0, 2'b00, 2'b01);
      check("drop_gnt", 64'(m_gnt), 64'd1);
      @(posedge clk); #1; rst = 1'b1; m_req = 2'b00;
      @(negedge clk);
      check("drop_rvalid", 64'(m_rvalid), 64'd0);
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      check("rst2_rvalid", 64'(m_rvalid), 64'd0);
      check("rst2_cnt",    64'(err_count), 64'd0);
      check("rst2_eaddr",  64'(err_address), 64'd0);
      drive(2'b11, RAM_BASE + 30'd4, 30'h100, 2'b00, 2'b11);
      check("rst2_first_gnt", 64'(m_gnt), 64'd1);
      push(2'b01, 2'b00, 32'hDEAD_BEEF, 1'b0, 16'd0, 30'd0);

      // Saturation: 70000 write misses.
      for (int i = 0; i < 70000; i++) begin
         drive(2'b01, MISS_A, 30'd0, 2'b01, 2'b00);
         push(2'b00, 2'b01, 32'd0, 1'b0, 16'd0, 30'd0);
      end
      drive(2'b00, 30'd0, 30'd0, 2'b00, 2'b00);
      check("sat_cnt",   64'(err_count), 64'hFFFF);
      check("sat_eaddr", 64'(err_address), 64'(MISS_A));

      repeat (3) drive(2'b00, 30'd0, 30'd0, 2'b00, 2'b00);
      check("queue_empty", 64'(q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
